// File: rtl/mem_map_router_pkg.sv
// Shared types and constants for the memory-map router and its address decoder.
// - did_t          : device ID; values 0..6 double as device channel indices, DNON = unmapped
// - router_state_t : router FSM states
// - MM_BASE_DEFAULT / MM_MASK_DEFAULT : default region table, region i at [i*16 +: 16]
package mem_map_router_pkg;

  localparam int MM_ADDR_W  = 16;
  localparam int MM_DATA_W  = 256;
  localparam int MM_MAX_DEV = 7;

  typedef enum logic [2:0] {
    DRAM = 3'd0,
    DROM = 3'd1,
    DMAT = 3'd2,
    DINT = 3'd3,
    DREG = 3'd4,
    DEXE = 3'd5,
    DSPI = 3'd6,
    DNON = 3'd7
  } did_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } router_state_t;

  // Region 0 sits in the least significant slice. DINT..DSPI overlap DMAT's
  // mask footprint only above 0xCFFF, so lowest-index priority is harmless here.
  localparam logic [MM_MAX_DEV*MM_ADDR_W-1:0] MM_BASE_DEFAULT = {
    16'hD300,  // DSPI
    16'hD200,  // DEXE
    16'hD100,  // DREG
    16'hD000,  // DINT
    16'hC000,  // DMAT
    16'h8000,  // DROM
    16'h0000   // DRAM
  };

  localparam logic [MM_MAX_DEV*MM_ADDR_W-1:0] MM_MASK_DEFAULT = {
    16'hFF00,  // DSPI
    16'hFF00,  // DEXE
    16'hFF00,  // DREG
    16'hFF00,  // DINT
    16'hF000,  // DMAT
    16'hC000,  // DROM
    16'h8000   // DRAM
  };

endpackage

// File: rtl/mem_map_router_if.sv
// Bus interfaces of the memory-map router.
// mem_req_if : core-side request/response channel
//   master = core (drives req_*, rsp_ready), slave = router (drives req_ready, rsp_*)
// mem_dev_if : router-to-device channels, one strobe bit per device
//   master = router (drives dev_valid/addr/we/wdata), slave = device set
interface mem_req_if
  import mem_map_router_pkg::*;
#(
  parameter int ADDR_W = MM_ADDR_W,
  parameter int DATA_W = MM_DATA_W
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  did_t              rsp_did;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_did
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_did
  );
endinterface

interface mem_dev_if
  import mem_map_router_pkg::*;
#(
  parameter int ADDR_W  = MM_ADDR_W,
  parameter int DATA_W  = MM_DATA_W,
  parameter int NUM_DEV = MM_MAX_DEV
);
  logic [NUM_DEV-1:0]        dev_valid;
  logic [NUM_DEV-1:0]        dev_ready;
  logic [ADDR_W-1:0]         dev_addr;
  logic                      dev_we;
  logic [DATA_W-1:0]         dev_wdata;
  logic [NUM_DEV-1:0]        dev_rsp_valid;
  logic [NUM_DEV*DATA_W-1:0] dev_rsp_rdata;

  modport master (
    output dev_valid, dev_addr, dev_we, dev_wdata,
    input  dev_ready, dev_rsp_valid, dev_rsp_rdata
  );

  modport slave (
    input  dev_valid, dev_addr, dev_we, dev_wdata,
    output dev_ready, dev_rsp_valid, dev_rsp_rdata
  );
endinterface

// File: rtl/mem_map_router_addr_region_decoder.sv
// addr_region_decoder: combinational priority matcher, address -> device ID.
// Region i hits when (i_addr & MASK[i]) == BASE[i]; the lowest hitting index
// wins; no hit yields DNON. Shared with the fetch path, so it holds no state.
// Ports:
//   i_addr : address to classify
//   o_did  : matching device ID, or DNON
module addr_region_decoder
  import mem_map_router_pkg::*;
#(
  parameter int                          ADDR_W      = MM_ADDR_W,
  parameter int                          NUM_DEV     = MM_MAX_DEV,
  parameter logic [NUM_DEV*ADDR_W-1:0]   REGION_BASE = MM_BASE_DEFAULT[NUM_DEV*ADDR_W-1:0],
  parameter logic [NUM_DEV*ADDR_W-1:0]   REGION_MASK = MM_MASK_DEFAULT[NUM_DEV*ADDR_W-1:0]
) (
  input  logic [ADDR_W-1:0] i_addr,
  output did_t              o_did
);

  logic [NUM_DEV-1:0] w_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DEV; gi++) begin : g_hit
      assign w_hit[gi] = ((i_addr & REGION_MASK[gi*ADDR_W +: ADDR_W])
                          == REGION_BASE[gi*ADDR_W +: ADDR_W]);
    end
  endgenerate

  // Scan from the top down so the lowest hitting index is written last.
  always_comb begin
    o_did = DNON;
    for (int i = NUM_DEV - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        o_did = did_t'(3'(i));
      end
    end
  end

endmodule

// File: rtl/mem_map_router.sv
// mem_map_router: single-outstanding request router between the core
// load/store path and the device set. Decodes the request address to a
// device, issues the request on that device's channel, waits for the device
// response and returns it. Unmapped addresses and devices that exceed TIMEOUT
// cycles in ISSUE+WAIT get an error response (rdata = 0).
// Ports:
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   req      : core-side request/response channel (slave view)
//   dev      : device channels (master view)
//   busy     : high whenever the FSM is not idle
module mem_map_router
  import mem_map_router_pkg::*;
#(
  parameter int                          ADDR_W      = MM_ADDR_W,
  parameter int                          DATA_W      = MM_DATA_W,
  parameter int                          NUM_DEV     = MM_MAX_DEV,
  parameter logic [NUM_DEV*ADDR_W-1:0]   REGION_BASE = MM_BASE_DEFAULT[NUM_DEV*ADDR_W-1:0],
  parameter logic [NUM_DEV*ADDR_W-1:0]   REGION_MASK = MM_MASK_DEFAULT[NUM_DEV*ADDR_W-1:0],
  parameter int                          TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       rst,
  mem_req_if.slave   req,
  mem_dev_if.master  dev,
  output logic       busy
);

  generate
    if (NUM_DEV < 1 || NUM_DEV > 7 || TIMEOUT < 1) begin : g_param_err
      $error("mem_map_router: NUM_DEV must be 1..7 and TIMEOUT >= 1");
    end
  endgenerate

  localparam int               CNT_W       = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  router_state_t     r_state,  w_state_next;
  logic [ADDR_W-1:0] r_addr,   w_addr_next;
  logic              r_we,     w_we_next;
  logic [DATA_W-1:0] r_wdata,  w_wdata_next;
  did_t              r_did,    w_did_next;
  logic [DATA_W-1:0] r_rdata,  w_rdata_next;
  logic              r_err,    w_err_next;
  logic [CNT_W-1:0]  r_cnt,    w_cnt_next;

  did_t              w_dec_did;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_timeout;
  logic              w_sel_ready;
  logic              w_sel_rsp;
  logic [DATA_W-1:0] w_sel_rdata;
  logic [NUM_DEV-1:0] w_dev_valid;

  addr_region_decoder #(
    .ADDR_W      (ADDR_W),
    .NUM_DEV     (NUM_DEV),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK)
  ) u_decoder (
    .i_addr (req.req_addr),
    .o_did  (w_dec_did)
  );

  // Only the channel of the registered device is observed; strobes on any
  // other channel are ignored.
  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_rsp   = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (r_did == did_t'(3'(i))) begin
        w_sel_ready = dev.dev_ready[i];
        w_sel_rsp   = dev.dev_rsp_valid[i];
        w_sel_rdata = dev.dev_rsp_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Counter value after this ISSUE/WAIT cycle; the transaction times out on
  // the cycle where it reaches TIMEOUT.
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_timeout = (w_cnt_inc == TIMEOUT_CNT);

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_we_next    = r_we;
    w_wdata_next = r_wdata;
    w_did_next   = r_did;
    w_rdata_next = r_rdata;
    w_err_next   = r_err;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (req.req_valid) begin
          w_addr_next  = req.req_addr;
          w_we_next    = req.req_we;
          w_wdata_next = req.req_wdata;
          w_did_next   = w_dec_did;
          w_rdata_next = '0;
          w_cnt_next   = '0;
          if (w_dec_did == DNON) begin
            w_err_next   = 1'b1;
            w_state_next = RESP;
          end else begin
            w_err_next   = 1'b0;
            w_state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        w_cnt_next = w_cnt_inc;
        if (w_timeout) begin
          w_err_next   = 1'b1;
          w_state_next = RESP;
        end else if (w_sel_ready) begin
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        w_cnt_next = w_cnt_inc;
        // A response arriving on the timeout cycle still counts.
        if (w_sel_rsp) begin
          w_rdata_next = w_sel_rdata;
          w_err_next   = 1'b0;
          w_state_next = RESP;
        end else if (w_timeout) begin
          w_err_next   = 1'b1;
          w_state_next = RESP;
        end
      end
      RESP: begin
        if (req.rsp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_did   <= DNON;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
      r_we    <= w_we_next;
      r_wdata <= w_wdata_next;
      r_did   <= w_did_next;
      r_rdata <= w_rdata_next;
      r_err   <= w_err_next;
      r_cnt   <= w_cnt_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DEV; gi++) begin : g_dev_valid
      assign w_dev_valid[gi] = (r_state == ISSUE) && (r_did == did_t'(3'(gi)));
    end
  endgenerate

  assign dev.dev_valid = w_dev_valid;
  assign dev.dev_addr  = r_addr;
  assign dev.dev_we    = r_we;
  assign dev.dev_wdata = r_wdata;

  assign req.req_ready = (r_state == IDLE);
  assign req.rsp_valid = (r_state == RESP);
  assign req.rsp_rdata = r_rdata;
  assign req.rsp_err   = r_err;
  assign req.rsp_did   = r_did;

  assign busy = (r_state != IDLE);

endmodule
